// File: rtl/aes_bist_ctrl.sv
// ---------------------------------------------------------------------------
// aes_bist_ctrl
//
// Sequencer for one built-in self-test of the 8-bit AES datapath. It sits
// upstream of the BIST top that holds the key/data LFSRs and the output MISR.
// One test runs in this order:
//   1. Clear the LFSR/MISR pair.
//   2. Hold their shared enable high for NUM_PATTERNS cycles.
//   3. Freeze the MISR and capture its signature.
//   4. Compare the signature with GOLDEN_SIG and hold the pass/fail result
//      until the next test or reset.
//
// Ports:
//   clk          - system clock
//   rst          - synchronous, active-high reset
//   start        - request a test; sampled only in IDLE or DONE
//   abort        - cancel a running test; sampled in CLEAR, RUN, CAPTURE
//   misr_sig     - current MISR signature from the BIST top
//   bist_clr     - synchronous clear to the LFSRs and MISR (drive into their rst)
//   lfsr_misr_en - shared enable to the LFSRs and MISR
//   busy         - high in CLEAR, RUN, CAPTURE
//   done         - high in DONE
//   pass         - high in DONE when the captured signature matches GOLDEN_SIG
//   sig_out      - last captured signature
//   pattern_cnt  - enabled cycles completed in the current or last run
// ---------------------------------------------------------------------------
module aes_bist_ctrl #(
    parameter int         NUM_PATTERNS = 16,
    parameter logic [7:0] GOLDEN_SIG   = 8'hC0,
    parameter int         CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       misr_sig,
    output logic             bist_clr,
    output logic             lfsr_misr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       sig_out,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    // Count value seen during the final RUN cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    logic [2:0] state;
    logic       result;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the values from before the edge.
    // NOTE: the reset is synchronous, so it takes effect only at a clock edge
    // and is not in the sensitivity list. Every register, including sig_out
    // and the result flag, returns to a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sig_out     <= '0;
            pattern_cnt <= '0;
            result      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLEAR;
                        pattern_cnt <= '0;
                    end
                end
                CLEAR: begin
                    pattern_cnt <= '0;
                    state       <= abort ? IDLE : RUN;
                end
                RUN: begin
                    // On abort the counter keeps its partial value so that
                    // software can see how far the run got.
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        pattern_cnt <= pattern_cnt + CNT_W'(1);
                        if (pattern_cnt == LAST_CNT) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // The enable is already low here, so misr_sig is stable.
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        sig_out <= misr_sig;
                        result  <= (misr_sig == GOLDEN_SIG);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state       <= CLEAR;
                        pattern_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decodes only: no path from any input to these outputs.
    assign bist_clr     = (state == CLEAR);
    assign lfsr_misr_en = (state == RUN);
    assign busy         = (state == CLEAR) || (state == RUN) || (state == CAPTURE);
    assign done         = (state == DONE);
    assign pass         = (state == DONE) && result;

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_bist_ctrl
//
// Directed testbench for aes_bist_ctrl. It uses two instances:
//   dut_a - NUM_PATTERNS = 4
//   dut_b - NUM_PATTERNS = 1 (boundary case)
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled in
// the same slot, which is safe because all outputs are Moore decodes.
// ---------------------------------------------------------------------------
module tb_aes_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // -------------------------------------------------------------------
    // dut_a: NUM_PATTERNS = 4
    // -------------------------------------------------------------------
    logic       start_a = 1'b0;
    logic       abort_a = 1'b0;
    logic [7:0] misr_a  = 8'h55;
    logic       clr_a;
    logic       en_a;
    logic       busy_a;
    logic       done_a;
    logic       pass_a;
    logic [7:0] sig_a;
    logic [2:0] cnt_a;

    aes_bist_ctrl #(
        .NUM_PATTERNS (4),
        .GOLDEN_SIG   (8'hC0)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start_a),
        .abort        (abort_a),
        .misr_sig     (misr_a),
        .bist_clr     (clr_a),
        .lfsr_misr_en (en_a),
        .busy         (busy_a),
        .done         (done_a),
        .pass         (pass_a),
        .sig_out      (sig_a),
        .pattern_cnt  (cnt_a)
    );

    // -------------------------------------------------------------------
    // dut_b: NUM_PATTERNS = 1
    // -------------------------------------------------------------------
    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [7:0] misr_b  = 8'h00;
    logic       clr_b;
    logic       en_b;
    logic       busy_b;
    logic       done_b;
    logic       pass_b;
    logic [7:0] sig_b;
    logic [0:0] cnt_b;

    aes_bist_ctrl #(
        .NUM_PATTERNS (1),
        .GOLDEN_SIG   (8'hC0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start_b),
        .abort        (abort_b),
        .misr_sig     (misr_b),
        .bist_clr     (clr_b),
        .lfsr_misr_en (en_b),
        .busy         (busy_b),
        .done         (done_b),
        .pass         (pass_b),
        .sig_out      (sig_b),
        .pattern_cnt  (cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Counts one comparison and prints a FAIL line on mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advances to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs dut_a's control outputs as {bist_clr, en, busy, done, pass}.
    function automatic logic [4:0] ctl_a();
        return {clr_a, en_a, busy_a, done_a, pass_a};
    endfunction

    // Packs dut_b's control outputs in the same order.
    function automatic logic [4:0] ctl_b();
        return {clr_b, en_b, busy_b, done_b, pass_b};
    endfunction

    // Runs one full test on dut_a.
    //   sig        - value driven on misr_sig during the CAPTURE cycle
    //   hold_start - keep start high for the whole run (and afterwards)
    task automatic run_a(input logic [7:0] sig, input bit hold_start, input string tag);
        start_a = 1'b1;
        misr_a  = 8'h55;
        step();                                   // cycle 1: CLEAR
        if (!hold_start) start_a = 1'b0;
        check({tag, "_clr_ctl"}, 32'(ctl_a()), 32'b10100);
        check({tag, "_clr_cnt"}, 32'(cnt_a),   32'd0);

        for (int i = 0; i < 4; i++) begin         // cycles 2..5: RUN
            step();
            check($sformatf("%s_run%0d_ctl", tag, i), 32'(ctl_a()), 32'b01100);
            check($sformatf("%s_run%0d_cnt", tag, i), 32'(cnt_a),   32'(i));
        end

        step();                                   // cycle 6: CAPTURE
        misr_a = sig;
        check({tag, "_cap_ctl"}, 32'(ctl_a()), 32'b00100);
        check({tag, "_cap_cnt"}, 32'(cnt_a),   32'd4);

        step();                                   // cycle 7: DONE
        misr_a = 8'h55;
        check({tag, "_done_ctl"}, 32'(ctl_a()), (sig == 8'hC0) ? 32'b00011 : 32'b00010);
        check({tag, "_done_sig"}, 32'(sig_a),   32'(sig));
        check({tag, "_done_cnt"}, 32'(cnt_a),   32'd4);
    endtask

    // Watchdog: stops the run if it somehow never reaches the summary.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset from power-up ----------------
        repeat (3) step();
        rst = 1'b0;
        check("rst_ctl_a", 32'(ctl_a()), 32'd0);
        check("rst_sig_a", 32'(sig_a),   32'd0);
        check("rst_cnt_a", 32'(cnt_a),   32'd0);
        check("rst_ctl_b", 32'(ctl_b()), 32'd0);

        // Idle with abort high: nothing should happen.
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("idle_abort_ctl", 32'(ctl_a()), 32'd0);

        // ---------------- Nominal pass ----------------
        run_a(8'hC0, 1'b0, "pass");
        step();
        check("done_hold_ctl", 32'(ctl_a()), 32'b00011);
        check("done_hold_sig", 32'(sig_a),   32'hC0);

        // ---------------- Signature mismatch ----------------
        run_a(8'h3A, 1'b0, "fail");

        // Capture a good signature again before the abort test.
        run_a(8'hC0, 1'b0, "pre");

        // ---------------- Abort in the 3rd RUN cycle ----------------
        start_a = 1'b1;
        step();                                   // CLEAR
        start_a = 1'b0;
        step();                                   // RUN, cnt = 0
        step();                                   // RUN, cnt = 1
        step();                                   // RUN, cnt = 2
        abort_a = 1'b1;
        step();                                   // IDLE
        abort_a = 1'b0;
        check("abort_ctl", 32'(ctl_a()), 32'd0);
        check("abort_cnt", 32'(cnt_a),   32'd2);
        check("abort_sig", 32'(sig_a),   32'hC0);

        // ---------------- Abort in CLEAR ----------------
        start_a = 1'b1;
        step();                                   // CLEAR
        start_a = 1'b0;
        abort_a = 1'b1;
        step();                                   // IDLE
        abort_a = 1'b0;
        check("abort_clr_ctl", 32'(ctl_a()), 32'd0);
        check("abort_clr_cnt", 32'(cnt_a),   32'd0);

        // ---------------- Abort in CAPTURE: sig_out not updated ----------------
        start_a = 1'b1;
        step();                                   // CLEAR
        start_a = 1'b0;
        repeat (4) step();                        // RUN x4
        step();                                   // CAPTURE
        misr_a  = 8'h77;
        abort_a = 1'b1;
        step();                                   // IDLE
        abort_a = 1'b0;
        misr_a  = 8'h55;
        check("abort_cap_ctl", 32'(ctl_a()), 32'd0);
        check("abort_cap_sig", 32'(sig_a),   32'hC0);

        // ---------------- start held high: no restart while busy ----------------
        // The second run starts straight from DONE, so its CLEAR checks
        // that done and pass drop and that the timing repeats.
        run_a(8'hC0, 1'b1, "hold1");
        run_a(8'h3A, 1'b1, "hold2");
        start_a = 1'b0;

        // ---------------- start and abort together in DONE: start wins ----------------
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_abort_done", 32'(ctl_a()), 32'b10100);
        repeat (5) step();                        // RUN x4, CAPTURE
        misr_a = 8'hC0;
        step();                                   // DONE
        misr_a = 8'h55;
        check("start_abort_fin", 32'(ctl_a()), 32'b00011);

        // ---------------- Boundary: NUM_PATTERNS = 1 ----------------
        start_b = 1'b1;
        step();                                   // cycle 1: CLEAR
        start_b = 1'b0;
        check("b_clr_ctl", 32'(ctl_b()), 32'b10100);
        step();                                   // cycle 2: RUN
        check("b_run_ctl", 32'(ctl_b()), 32'b01100);
        check("b_run_cnt", 32'(cnt_b),   32'd0);
        step();                                   // cycle 3: CAPTURE
        misr_b = 8'hC0;
        check("b_cap_ctl", 32'(ctl_b()), 32'b00100);
        check("b_cap_cnt", 32'(cnt_b),   32'd1);
        step();                                   // cycle 4: DONE
        misr_b = 8'h00;
        check("b_done_ctl", 32'(ctl_b()), 32'b00011);
        check("b_done_sig", 32'(sig_b),   32'hC0);

        // ---------------- Reset mid-RUN ----------------
        start_a = 1'b1;
        step();                                   // CLEAR
        start_a = 1'b0;
        step();                                   // RUN, cnt = 0
        step();                                   // RUN, cnt = 1
        rst = 1'b1;
        step();
        check("mid_rst_ctl", 32'(ctl_a()), 32'd0);
        check("mid_rst_sig", 32'(sig_a),   32'd0);
        check("mid_rst_cnt", 32'(cnt_a),   32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_ctl", 32'(ctl_a()), 32'd0);
        check("post_rst_b",   32'(sig_b),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
